// File: rtl/mem_responder_if.sv
// Load/store handshake bundle between a core (master) and its data memory (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word data memory with programmable response latency.
// Define MEM_RESPONDER_STATS_EN to add saturating read/write/error response counters.
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | latency countdown; the access happens on the edge leaving this state
// RESP  | response held stable until resp_ready
module mem_responder #(
    parameter int unsigned BYTES   = 1024,
    parameter logic [31:0] START   = 32'h10008000,
    parameter int unsigned LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    mem_responder_if.slave bus
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [15:0] err_count
`endif
);
    localparam int unsigned WORDS    = BYTES / 4;
    localparam int unsigned IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] LAST_OFF = 32'(BYTES - 4);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0]      mem_q [WORDS];
    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic             mem_we;

    // Offset is a full 32-bit difference: addresses below START wrap high and miss.
    assign off = addr_q - START;
    assign hit = (addr_q >= START) && (off <= LAST_OFF) && (addr_q[1:0] == 2'b00);
    assign idx = off[IDX_W+1:2];

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic [15:0] err_count_q, err_count_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;
`ifdef MEM_RESPONDER_STATS_EN
        rd_count_d   = rd_count_q;
        wr_count_d   = wr_count_q;
        err_count_d  = err_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    write_d     = bus.req_write;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    wstrb_d     = bus.req_wstrb;
                    cnt_d       = CNT_INIT;
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    mem_we       = write_q && hit;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !hit;
                    resp_rdata_d = (!write_q && hit) ? mem_q[idx] : 32'd0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
`ifdef MEM_RESPONDER_STATS_EN
                    if (resp_err_q) begin
                        if (err_count_q != '1) err_count_d = err_count_q + 16'd1;
                    end else if (write_q) begin
                        if (wr_count_q != '1) wr_count_d = wr_count_q + 32'd1;
                    end else begin
                        if (rd_count_q != '1) rd_count_d = rd_count_q + 32'd1;
                    end
`endif
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage is deliberately left out of reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
`ifdef MEM_RESPONDER_STATS_EN
            rd_count_q   <= 32'd0;
            wr_count_q   <= 32'd0;
            err_count_q  <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef MEM_RESPONDER_STATS_EN
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
            err_count_q  <= err_count_d;
`endif
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

`ifdef MEM_RESPONDER_STATS_EN
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with LATENCY=2, 1 KiB window at 0x10008000.
module tb_mem_responder;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    mem_responder_if bus ();

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [15:0] err_count;
`endif

    mem_responder #(
        .BYTES   (1024),
        .START   (32'h10008000),
        .LATENCY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_RESPONDER_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request, waits (bounded) for acceptance and response; completes the
    // response handshake unless hold is set. lat counts edges from acceptance to resp_valid.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit hold, output bit to,
                          output int lat, output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        to = (n >= 20) || (lat >= 20);
        rd = bus.resp_rdata;
        er = bus.resp_err;
        if (!hold) begin
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.resp_ready = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        n_chk++; if (bus.resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h expected 0", bus.resp_rdata); end
        n_chk++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
    endtask

    task automatic test_store_load();
        bit to; int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10008004, 32'hDEADBEEF, 4'hF, 1'b0, to, lat, rd, er);
        n_chk++; if (to) begin n_fail++; $display("FAIL t1_store_timeout: got timeout expected response"); end
        n_chk++; if (lat != 2) begin n_fail++; $display("FAIL t1_store_latency: got %0d expected 2", lat); end
        n_chk++; if (er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL t1_store_resp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
        do_req(1'b0, 32'h10008004, 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        n_chk++; if (to || lat != 2) begin n_fail++; $display("FAIL t1_load_latency: got %0d expected 2", lat); end
        n_chk++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL t1_load_rdata: got %h err=%b expected deadbeef err=0", rd, er); end
    endtask

    task automatic test_byte_strobe();
        bit to; int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10008004, 32'h000000AA, 4'b0001, 1'b0, to, lat, rd, er);
        do_req(1'b0, 32'h10008004, 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        n_chk++; if (to || rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL t2_strobe_rdata: got %h expected deadbeaa", rd); end
        do_req(1'b1, 32'h10008004, 32'h55AA0000, 4'b0100, 1'b0, to, lat, rd, er);
        do_req(1'b0, 32'h10008004, 32'h0, 4'hF, 1'b0, to, lat, rd, er);
        n_chk++; if (to || rd !== 32'hDEAABEAA) begin n_fail++; $display("FAIL t2_lane2_rdata: got %h expected deaabeaa", rd); end
        do_req(1'b1, 32'h10008004, 32'hFFFFFFFF, 4'b0000, 1'b0, to, lat, rd, er);
        n_chk++; if (to || er !== 1'b0) begin n_fail++; $display("FAIL t2_zero_strb_err: got %b expected 0", er); end
        do_req(1'b0, 32'h10008004, 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        n_chk++; if (to || rd !== 32'hDEAABEAA) begin n_fail++; $display("FAIL t2_zero_strb_rdata: got %h expected deaabeaa", rd); end
    endtask

    task automatic test_errors();
        bit to; int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10008000, 32'h11223344, 4'hF, 1'b0, to, lat, rd, er);
        do_req(1'b1, 32'h100083FC, 32'h55667788, 4'hF, 1'b0, to, lat, rd, er);
        do_req(1'b0, 32'h10008002, 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        n_chk++; if (to || er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL t3_misaligned: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
        do_req(1'b1, 32'h10007FFC, 32'hCAFEF00D, 4'hF, 1'b0, to, lat, rd, er);
        n_chk++; if (to || er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL t3_below_start: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
        do_req(1'b1, 32'h10008400, 32'hCAFEF00D, 4'hF, 1'b0, to, lat, rd, er);
        n_chk++; if (to || er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL t3_past_end: got err=%b rdata=%h expected err=1 rdata=0", er, rd); end
        do_req(1'b0, 32'h10008000, 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        n_chk++; if (to || er !== 1'b0 || rd !== 32'h11223344) begin n_fail++; $display("FAIL t3_first_word: got %h err=%b expected 11223344 err=0", rd, er); end
        do_req(1'b0, 32'h100083FC, 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        n_chk++; if (to || er !== 1'b0 || rd !== 32'h55667788) begin n_fail++; $display("FAIL t3_last_word: got %h err=%b expected 55667788 err=0", rd, er); end
    endtask

    task automatic test_resp_stall();
        bit to; int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 32'h10008004, 32'h0, 4'h0, 1'b1, to, lat, rd, er);
        n_chk++; if (to || rd !== 32'hDEAABEAA) begin n_fail++; $display("FAIL t4_first_rdata: got %h expected deaabeaa", rd); end
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_addr  = 32'h10008004;
            bus.req_wdata = 32'h01020304;
            bus.req_wstrb = 4'hF;
            @(posedge clk);
            #1;
            n_chk++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEAABEAA || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL t4_hold_cycle%0d: got valid=%b rdata=%h err=%b ready=%b expected 1 deaabeaa 0 0",
                         i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
            end
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        n_chk++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL t4_release: got valid=%b ready=%b rdata=%h expected 0 1 0", bus.resp_valid, bus.req_ready, bus.resp_rdata);
        end
        do_req(1'b0, 32'h10008004, 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        n_chk++; if (to || rd !== 32'hDEAABEAA) begin n_fail++; $display("FAIL t4_ignored_store: got %h expected deaabeaa", rd); end
    endtask

    task automatic test_reset_mid();
        bit to; int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10008010, 32'h0BADF00D, 4'hF, 1'b0, to, lat, rd, er);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h10008010;
        bus.req_wdata = 32'h12345678;
        bus.req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_reset_outputs: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        do_req(1'b0, 32'h10008010, 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        n_chk++; if (to || rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL t5_old_value: got %h expected 0badf00d", rd); end
    endtask

`ifdef MEM_RESPONDER_STATS_EN
    task automatic test_stats();
        bit to; int lat; logic [31:0] rd; logic er;
        pulse_reset();
        for (int i = 0; i < 3; i++) do_req(1'b0, 32'h10008000 + 32'(4 * i), 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        for (int i = 0; i < 2; i++) do_req(1'b1, 32'h10008100 + 32'(4 * i), 32'hA5A5A5A5, 4'hF, 1'b0, to, lat, rd, er);
        do_req(1'b0, 32'h10008001, 32'h0, 4'h0, 1'b0, to, lat, rd, er);
        n_chk++; if (rd_count !== 32'd3) begin n_fail++; $display("FAIL t6_rd_count: got %0d expected 3", rd_count); end
        n_chk++; if (wr_count !== 32'd2) begin n_fail++; $display("FAIL t6_wr_count: got %0d expected 2", wr_count); end
        n_chk++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL t6_err_count: got %0d expected 1", err_count); end
        pulse_reset();
        n_chk++;
        if (rd_count !== 32'd0 || wr_count !== 32'd0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL t6_clear: got rd=%0d wr=%0d err=%0d expected 0 0 0", rd_count, wr_count, err_count);
        end
    endtask
`endif

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_wstrb  = 4'd0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_byte_strobe();
        test_errors();
        test_resp_stall();
        test_reset_mid();
`ifdef MEM_RESPONDER_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Handshaked data-memory responder: the memory-side end of the processor load/store interface.
- Accepts one word read/write request at a time, holds it for a programmable latency, then returns a response.
- Used as the data memory behind multi-cycle/pipelined cores and for testing stall handling in the core.
- Word-addressed storage mapped at START, little-endian, with byte-lane write strobes.

Parameters:
- BYTES, 1024, storage size in bytes; multiple of 4.
- START, 'h10008000, base byte address of the storage window.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte-lane enables; bit i selects bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was out of range or misaligned.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Storage contents are not cleared.
- Reset mid-transaction: the transaction is dropped. If the store has not yet committed, no bytes change.
- State machine:
  - IDLE: req_ready=1. On req_valid&req_ready, capture write/addr/wdata/wstrb, load counter=LATENCY-1, go to WAIT.
  - WAIT: req_ready=0. If counter==0, perform the access and go to RESP; otherwise decrement.
  - RESP: resp_valid=1, outputs held stable. On resp_valid&resp_ready, go to IDLE.
- Latency: request accepted at edge N → resp_valid high after edge N+LATENCY.
- Back-to-back: next acceptance occurs no earlier than the edge after the response handshake; req_ready is low in WAIT/RESP.
- Access timing:
  - Performed at the WAIT→RESP edge.
  - A store commits only the enabled byte lanes at that edge.
  - A load samples the word at that edge and sees all prior committed stores.
- Error: resp_err=1 if addr<START, addr>START+BYTES-4, or addr[1:0]≠0. Errored stores write nothing; errored loads return 0.
- req_wstrb is ignored for loads; a store with wstrb=0 succeeds and changes nothing.
- Index arithmetic: word index = (addr-START)>>2, computed in 32 bits with no wrap. An address below START must not alias into the array.
- resp_rdata and resp_err are 0 whenever resp_valid=0.

Optional Feature:
- Macro: MEM_RESPONDER_STATS_EN.
- Defined:
  - Adds outputs rd_count (32), wr_count (32) and err_count (16).
  - Each counter increments at the response handshake: rd_count for a non-error load, wr_count for a non-error store, err_count for any error.
  - Counters clear on rst and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Store 0xDEADBEEF, wstrb=4'hF, to 0x10008004, LATENCY=2; then load 0x10008004 → store resp_valid 2 cycles after acceptance with err=0; load returns 0xDEADBEEF.
2. Store 0x000000AA, wstrb=4'b0001, to 0x10008004 over test 1, then load → 0xDEADBEAA.
3. Load 0x10008002, then store to 0x10007FFC and to START+BYTES → all three give resp_err=1 and rdata=0; a following load of 0x10007FFC's nearest valid word shows it unchanged.
4. Hold resp_ready=0 for 5 cycles after a load completes → resp_valid, rdata and err stay stable, req_ready=0, a new req_valid is ignored; raise resp_ready → IDLE next cycle.
5. Assert rst in WAIT during a store of 0x12345678 to 0x10008010 → outputs return to reset values; a later load of 0x10008010 returns the old value.
6. With MEM_RESPONDER_STATS_EN: 3 good loads, 2 good stores, 1 error → rd_count=3, wr_count=2, err_count=1; rst clears all three to 0.
